// File: rtl/mux_sel_rr_reg.sv
// -----------------------------------------------------------------------------
// mux_sel_rr_reg
//   Registered N:1 channel multiplexer with valid/ready flow control.
//   mode=0 picks the channel named by sel; mode=1 arbitrates round-robin
//   among the channels presenting valid data.  A single output register stage
//   holds the selected word and the index of the channel it came from.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   mode       0 = direct select by sel, 1 = round-robin
//   sel        channel index (direct mode only)
//   in_data    flattened channel data, channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept (combinational, one-hot or zero)
//   out_data   registered output word
//   out_valid  registered output valid
//   out_ready  downstream accept
//   grant      registered index of the channel held in out_data
// -----------------------------------------------------------------------------
module mux_sel_rr_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          grant
);

    // Last channel served in round-robin mode; the search starts just after it.
    logic [SEL_W-1:0] ptr_r;

    logic             open_s;
    logic             cand_found_s;
    logic [SEL_W-1:0] cand_idx_s;
    logic [WIDTH-1:0] cand_data_s;
    logic             transfer_s;

    // (base + step) mod CHANNELS; base < CHANNELS and step <= CHANNELS, so a
    // single conditional subtraction is enough even for non-power-of-2 counts.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                  input int               step);
        int sum;
        sum = int'(base) + step;
        if (sum >= CHANNELS) begin
            sum = sum - CHANNELS;
        end else begin
            sum = sum + 0;
        end
        return sum[SEL_W-1:0];
    endfunction

    // The output register can take a new word when empty or emptying now.
    assign open_s = !out_valid || out_ready;

    // Candidate channel selection for both modes.
    always_comb begin
        cand_found_s = 1'b0;
        cand_idx_s   = '0;
        if (mode == 1'b0) begin
            if (int'(sel) < CHANNELS) begin
                cand_found_s = 1'b1;
                cand_idx_s   = sel;
            end else begin
                cand_found_s = 1'b0;
                cand_idx_s   = '0;
            end
        end else begin
            // Walk from the farthest position back to ptr+1 so the last hit
            // written is the nearest valid channel after ptr.
            for (int k = CHANNELS; k >= 1; k--) begin
                if (in_valid[wrap_add(ptr_r, k)]) begin
                    cand_found_s = 1'b1;
                    cand_idx_s   = wrap_add(ptr_r, k);
                end else begin
                    cand_found_s = cand_found_s;
                    cand_idx_s   = cand_idx_s;
                end
            end
        end
    end

    // One-hot ready toward the candidate and data mux for the candidate.
    always_comb begin
        in_ready    = '0;
        cand_data_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(cand_idx_s) == i) begin
                in_ready[i] = open_s && cand_found_s;
                cand_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                in_ready[i] = 1'b0;
            end
        end
    end

    assign transfer_s = |(in_valid & in_ready);

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant     <= '0;
            ptr_r     <= SEL_W'(CHANNELS - 1);
        end else if (transfer_s) begin
            out_valid <= 1'b1;
            out_data  <= cand_data_s;
            grant     <= cand_idx_s;
            if (mode) begin
                ptr_r <= cand_idx_s;
            end
        end else if (out_ready) begin
            // Consumed with nothing to replace it; data and grant keep their values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_sel_rr_reg.sv
module tb_mux_sel_rr_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] in_data = 32'h0;
    logic [3:0]  in_valid = 4'b0;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  grant;

    // Three-channel instance for the out-of-range select case
    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = 2'd0;
    logic [23:0] d3 = 24'h0;
    logic [2:0]  v3 = 3'b0;
    logic [2:0]  r3;
    logic [7:0]  od3;
    logic        ov3;
    logic        ordy3 = 1'b1;
    logic [1:0]  g3;

    int vectors = 0;
    int checks = 0;
    int miscompares = 0;

    // Reference model state
    int          m_ptr = 3;
    bit          m_valid = 1'b0;
    logic [9:0]  sb_q[$];

    mux_sel_rr_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .grant(grant)
    );

    mux_sel_rr_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(d3),
        .in_valid(v3), .in_ready(r3), .out_data(od3),
        .out_valid(ov3), .out_ready(ordy3), .grant(g3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Channel chosen by the arbitration rules, or -1 when there is none.
    function automatic int model_cand(input bit md, input int s, input logic [3:0] v, input int ptr);
        int c;
        if (!md) return (s < 4) ? s : -1;
        for (int k = 1; k <= 4; k++) begin
            c = (ptr + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Applies one cycle of stimulus; called just after a rising edge.
    task automatic drive(input bit md, input int s, input logic [3:0] v,
                         input logic [31:0] d, input bit r);
        int         c;
        bit         open;
        logic [3:0] exp_rdy;
        mode = md; sel = s[1:0]; in_valid = v; in_data = d; out_ready = r;
        vectors++;
        open = !m_valid || r;
        c = model_cand(md, s, v, m_ptr);
        exp_rdy = (open && c >= 0) ? (4'b0001 << c) : 4'b0000;
        @(negedge clk);
        chk("in_ready", {28'h0, in_ready}, {28'h0, exp_rdy});
        @(posedge clk);
        if (open && c >= 0 && v[c]) begin
            sb_q.push_back({c[1:0], d[c*8 +: 8]});
            m_valid = 1'b1;
            if (md) m_ptr = c;
        end else if (r) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    // Monitor: checks occupancy every cycle and pops the scoreboard on each consume.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst) begin
            chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    miscompares++;
                    $display("FAIL scoreboard: got word %0h with nothing expected", {grant, out_data});
                end else begin
                    e = sb_q.pop_front();
                    chk("grant_data", {22'h0, grant, out_data}, {22'h0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  rv;
        logic [31:0] rd;
        // Power-on reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_data", {24'h0, out_data}, 32'h0);
        chk("rst_grant", {30'h0, grant}, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Direct select of channel 2
        drive(1'b0, 2, 4'b0100, 32'h00AC_0000, 1'b1);
        chk("direct_data", {24'h0, out_data}, 32'hAC);
        chk("direct_grant", {30'h0, grant}, 32'h2);

        // Backpressure: the held word must survive a changing input
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2, 4'b0100, 32'h000B_0000, 1'b0);
            chk("stall_data", {24'h0, out_data}, 32'hAC);
        end
        drive(1'b0, 2, 4'b0100, 32'h000B_0000, 1'b1);
        chk("after_stall", {24'h0, out_data}, 32'h0B);

        // Reset while a word is held
        drive(1'b0, 1, 4'b0010, 32'h0000_5A00, 1'b1);
        drive(1'b0, 1, 4'b0000, 32'h0000_0000, 1'b0);
        chk("held_before_rst", {31'h0, out_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_data", {24'h0, out_data}, 32'h0);
        chk("mid_rst_grant", {30'h0, grant}, 32'h0);
        m_valid = 1'b0; m_ptr = 3; sb_q.delete();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Round-robin with every channel valid: grants 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 0, 4'b1111, 32'h1312_1110, 1'b1);
            chk("rr_grant", {30'h0, grant}, i % 4);
        end
        // Skip and wrap: after grant 3, channels 0 and 3 alternate
        drive(1'b1, 0, 4'b1001, 32'h1312_1110, 1'b1);
        chk("wrap_grant0", {30'h0, grant}, 32'h0);
        drive(1'b1, 0, 4'b1001, 32'h1312_1110, 1'b1);
        chk("wrap_grant3", {30'h0, grant}, 32'h3);
        drive(1'b1, 0, 4'b1001, 32'h1312_1110, 1'b1);
        chk("wrap_grant0b", {30'h0, grant}, 32'h0);
        drive(1'b1, 0, 4'b0000, 32'h1312_1110, 1'b1);
        chk("idle_drop", {31'h0, out_valid}, 32'h0);

        // Randomised traffic with mode switches and backpressure
        for (int i = 0; i < 400; i++) begin
            rv = 4'($urandom);
            rd = $urandom;
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 3), rv, rd,
                  $urandom_range(0, 3) != 0);
        end

        // Drain
        for (int i = 0; i < 4; i++) drive(1'b0, 0, 4'b0000, 32'h0, 1'b1);
        chk("drained", sb_q.size(), 32'h0);

        // Three channels: sel=3 names no channel
        mode3 = 1'b0; sel3 = 2'd3; v3 = 3'b111; d3 = 24'hC3B2A1; ordy3 = 1'b1;
        @(negedge clk);
        chk("ch3_sel3_ready", {29'h0, r3}, 32'h0);
        @(posedge clk); #1;
        chk("ch3_sel3_valid", {31'h0, ov3}, 32'h0);
        sel3 = 2'd1;
        @(negedge clk);
        chk("ch3_sel1_ready", {29'h0, r3}, 32'h2);
        @(posedge clk); #1;
        chk("ch3_sel1_valid", {31'h0, ov3}, 32'h1);
        chk("ch3_sel1_data", {24'h0, od3}, 32'hB2);
        chk("ch3_sel1_grant", {30'h0, g3}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
